toysram_ra_ctl: RTL and testbench

- Parametrised array controller between the site config/address decoder and NUM_RA register arrays of depth 2^ADR_W x 32.
- Each array has two read ports and one write port.
- Adds three things to the single-array control path: multi-array select, configurable read latency, and byte-enable writes done as read-modify-write (RMW).
- One command is outstanding at a time; every accepted command receives exactly one rd_ack pulse.

---
 rtl/toysram_ra_pkg.sv | 18 +
 rtl/toysram_byte_merge.sv | 15 +
 rtl/toysram_ra_ctl.sv | 148 ++++++++++++++
 tb/tb_toysram_ra_ctl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toysram_ra_pkg.sv
// Shared encodings for the toysram array controller: FSM states, command field
// offsets and the data returned when no array supplies a word.
package toysram_ra_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD       = 3'd1;
   localparam logic [2:0] ST_RD_WAIT  = 3'd2;
   localparam logic [2:0] ST_RMW_RD   = 3'd3;
   localparam logic [2:0] ST_RMW_WAIT = 3'd4;
   localparam logic [2:0] ST_WR       = 3'd5;
   localparam logic [2:0] ST_ACK      = 3'd6;

   localparam int PORT_BIT = 15;
   localparam int IDX_LSB  = 16;

   localparam logic [31:0] RD_DAT_ERR = 32'h0;

endpackage

// File: rtl/toysram_byte_merge.sv
// Byte-lane merge: lanes with sel set take new_dat, the rest keep old_dat.
module toysram_byte_merge (
   input  logic [3:0]  sel,
   input  logic [31:0] new_dat,
   input  logic [31:0] old_dat,
   output logic [31:0] mrg_dat
);

   always_comb begin
      mrg_dat = old_dat;
      for (int b = 0; b < 4; b++)
         if (sel[b]) mrg_dat[8*b +: 8] = new_dat[8*b +: 8];
   end

endmodule

// File: rtl/toysram_ra_ctl.sv
// Multi-array register-file controller: one outstanding command, selectable read
// port, configurable read latency and byte-enable writes via read-modify-write.
module toysram_ra_ctl
   import toysram_ra_pkg::*;
#(
   parameter int NUM_RA = 2,
   parameter int ADR_W  = 5,
   parameter int RD_LAT = 1,
   parameter int IDX_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_val,
   output logic                     cmd_rdy,
   input  logic                     cmd_we,
   input  logic [31:0]              cmd_adr,
   input  logic [3:0]               cmd_sel,
   input  logic [31:0]              cmd_dat,
   output logic                     rd_ack,
   output logic [31:0]              rd_dat,
   output logic                     err,
   output logic [NUM_RA-1:0]        ra_r0_enb,
   output logic [ADR_W-1:0]         ra_r0_adr,
   input  logic [NUM_RA-1:0][31:0]  ra_r0_dat,
   output logic [NUM_RA-1:0]        ra_r1_enb,
   output logic [ADR_W-1:0]         ra_r1_adr,
   input  logic [NUM_RA-1:0][31:0]  ra_r1_dat,
   output logic [NUM_RA-1:0]        ra_w0_enb,
   output logic [ADR_W-1:0]         ra_w0_adr,
   output logic [31:0]              ra_w0_dat
);

   localparam int                CNT_W    = $clog2(RD_LAT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

   logic [2:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              port_q;
   logic [IDX_W-1:0]  idx_q;
   logic [ADR_W-1:0]  adr_q;
   logic [3:0]        sel_q;
   logic [31:0]       wdat_q;
   logic [31:0]       rd_dat_q;
   logic              err_q;

   logic [IDX_W-1:0]  cmd_idx;
   logic [ADR_W-1:0]  cmd_word;
   logic              idx_ok;
   logic [NUM_RA-1:0] arr_oh;
   logic [31:0]       rd_word;
   logic [31:0]       mrg_dat;
   logic              unused_adr;

   assign cmd_idx    = cmd_adr[IDX_LSB +: IDX_W];
   assign cmd_word   = cmd_adr[ADR_W+1:2];
   assign idx_ok     = (32'(cmd_idx) < NUM_RA);
   assign unused_adr = ^{cmd_adr[31:IDX_LSB+IDX_W], cmd_adr[PORT_BIT-1:ADR_W+2], cmd_adr[1:0]};

   // port_q is forced to 0 for writes so the RMW read always comes from port 0
   always_comb begin
      arr_oh  = '0;
      rd_word = RD_DAT_ERR;
      for (int i = 0; i < NUM_RA; i++)
         if (idx_q == IDX_W'(i)) begin
            arr_oh[i] = 1'b1;
            rd_word   = port_q ? ra_r1_dat[i] : ra_r0_dat[i];
         end
   end

   toysram_byte_merge u_merge (
      .sel     (sel_q),
      .new_dat (wdat_q),
      .old_dat (rd_word),
      .mrg_dat (mrg_dat)
   );

   // enables decode straight from state so an async reset drops them at once
   assign ra_r0_enb = ((state == ST_RD && !port_q) || state == ST_RMW_RD) ? arr_oh : '0;
   assign ra_r1_enb = (state == ST_RD && port_q) ? arr_oh : '0;
   assign ra_w0_enb = (state == ST_WR && cnt == '0) ? arr_oh : '0;
   assign ra_r0_adr = adr_q;
   assign ra_r1_adr = adr_q;
   assign ra_w0_adr = adr_q;
   assign ra_w0_dat = wdat_q;
   assign cmd_rdy   = (state == ST_IDLE);
   assign rd_ack    = (state == ST_ACK);
   assign rd_dat    = rd_dat_q;
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         port_q   <= 1'b0;
         idx_q    <= '0;
         adr_q    <= '0;
         sel_q    <= '0;
         wdat_q   <= '0;
         rd_dat_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (cmd_val) begin
               port_q   <= ~cmd_we & cmd_adr[PORT_BIT];
               idx_q    <= cmd_idx;
               adr_q    <= cmd_word;
               sel_q    <= cmd_sel;
               wdat_q   <= cmd_dat;
               rd_dat_q <= RD_DAT_ERR;
               cnt      <= '0;
               if (!idx_ok) begin
                  err_q <= 1'b1;
                  state <= ST_ACK;
               end else if (!cmd_we)       state <= ST_RD;
               else if (cmd_sel == 4'hF)   state <= ST_WR;
               else if (cmd_sel == 4'h0)   state <= ST_ACK;
               else                        state <= ST_RMW_RD;
            end
            ST_RD: begin
               cnt   <= '0;
               state <= ST_RD_WAIT;
            end
            ST_RD_WAIT:
               if (cnt == CNT_LAST) begin
                  rd_dat_q <= rd_word;
                  state    <= ST_ACK;
               end else cnt <= cnt + 1'b1;
            ST_RMW_RD: begin
               cnt   <= '0;
               state <= ST_RMW_WAIT;
            end
            ST_RMW_WAIT:
               if (cnt == CNT_LAST) begin
                  wdat_q <= mrg_dat;
                  cnt    <= '0;
                  state  <= ST_WR;
               end else cnt <= cnt + 1'b1;
            // write strobes in the first cycle; the second lets the array commit before ack
            ST_WR:
               if (cnt == '0) cnt <= cnt + 1'b1;
               else           state <= ST_ACK;
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_toysram_ra_ctl.sv
// Directed bench for toysram_ra_ctl: three controllers (RD_LAT 1..3) with
// behavioural arrays; port-1 data is tagged so the chosen port is visible.
module tb_toysram_ra_ctl;

   localparam int NUM_RA = 2;
   localparam int ADR_W  = 5;
   localparam int IDX_W  = 3;
   localparam logic [31:0] P1_TAG = 32'h0F0F_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  cmd_val = '0;
   logic        cmd_we  = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [3:0]  cmd_sel = '0;
   logic [31:0] cmd_dat = '0;

   logic              cmd_rdy_v [3];
   logic              rd_ack_v  [3];
   logic [31:0]       rd_dat_v  [3];
   logic              err_v     [3];
   logic [NUM_RA-1:0] r0_enb_v  [3];
   logic [NUM_RA-1:0] r1_enb_v  [3];
   logic [NUM_RA-1:0] w0_enb_v  [3];
   logic [ADR_W-1:0]  r0_adr_v  [3];
   logic [ADR_W-1:0]  r1_adr_v  [3];
   logic [ADR_W-1:0]  w0_adr_v  [3];
   logic [31:0]       w0_dat_v  [3];

   int n_chk  = 0;
   int n_fail = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = g + 1;
      logic [32*NUM_RA-1:0] r0_dat, r1_dat;
      logic [31:0] mem [NUM_RA][2**ADR_W];
      logic [31:0] p0  [NUM_RA][LAT];
      logic [31:0] p1  [NUM_RA][LAT];

      toysram_ra_ctl #(.NUM_RA(NUM_RA), .ADR_W(ADR_W), .RD_LAT(LAT), .IDX_W(IDX_W)) dut (
         .clk       (clk),
         .rst       (rst),
         .cmd_val   (cmd_val[g]),
         .cmd_rdy   (cmd_rdy_v[g]),
         .cmd_we    (cmd_we),
         .cmd_adr   (cmd_adr),
         .cmd_sel   (cmd_sel),
         .cmd_dat   (cmd_dat),
         .rd_ack    (rd_ack_v[g]),
         .rd_dat    (rd_dat_v[g]),
         .err       (err_v[g]),
         .ra_r0_enb (r0_enb_v[g]),
         .ra_r0_adr (r0_adr_v[g]),
         .ra_r0_dat (r0_dat),
         .ra_r1_enb (r1_enb_v[g]),
         .ra_r1_adr (r1_adr_v[g]),
         .ra_r1_dat (r1_dat),
         .ra_w0_enb (w0_enb_v[g]),
         .ra_w0_adr (w0_adr_v[g]),
         .ra_w0_dat (w0_dat_v[g])
      );

      // data is valid exactly LAT cycles after the enable cycle, garbage otherwise
      always @(posedge clk)
         for (int i = 0; i < NUM_RA; i++) begin
            if (w0_enb_v[g][i]) mem[i][w0_adr_v[g]] <= w0_dat_v[g];
            p0[i][0] <= r0_enb_v[g][i] ? mem[i][r0_adr_v[g]] : 32'hDEAD_BEEF;
            p1[i][0] <= r1_enb_v[g][i] ? (mem[i][r1_adr_v[g]] ^ P1_TAG) : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) begin
               p0[i][k] <= p0[i][k-1];
               p1[i][k] <= p1[i][k-1];
            end
         end

      always_comb begin
         r0_dat = '0;
         r1_dat = '0;
         for (int i = 0; i < NUM_RA; i++) begin
            r0_dat[32*i +: 32] = p0[i][LAT-1];
            r1_dat[32*i +: 32] = p1[i][LAT-1];
         end
      end
   end

   typedef struct {
      int ack_cyc, ack_cnt, r0_cyc, r1_cyc, w0_cyc, multi, rdy_busy;
      logic [NUM_RA-1:0] r0_enb, r1_enb, w0_enb;
      logic [ADR_W-1:0]  r0_adr, r1_adr, w0_adr;
      logic [31:0]       w0_dat, ack_dat;
   } obs_t;

   // Issue one command on instance g and record what happens over 14 cycles.
   // Cycle numbers are relative to the cycle in which the command is presented.
   task automatic do_cmd(input int g, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, output obs_t o);
      o = '{default: 0};
      o.ack_cyc = -1; o.r0_cyc = -1; o.r1_cyc = -1; o.w0_cyc = -1;
      @(negedge clk);
      cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat; cmd_val[g] = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         cmd_val[g] = 1'b0;
         if (rd_ack_v[g]) begin
            o.ack_cnt++;
            if (o.ack_cyc < 0) begin o.ack_cyc = c; o.ack_dat = rd_dat_v[g]; end
         end
         if (|r0_enb_v[g] && o.r0_cyc < 0) begin o.r0_cyc = c; o.r0_enb = r0_enb_v[g]; o.r0_adr = r0_adr_v[g]; end
         if (|r1_enb_v[g] && o.r1_cyc < 0) begin o.r1_cyc = c; o.r1_enb = r1_enb_v[g]; o.r1_adr = r1_adr_v[g]; end
         if (|w0_enb_v[g] && o.w0_cyc < 0) begin
            o.w0_cyc = c; o.w0_enb = w0_enb_v[g]; o.w0_adr = w0_adr_v[g]; o.w0_dat = w0_dat_v[g];
         end
         if ($countones({r0_enb_v[g], r1_enb_v[g], w0_enb_v[g]}) > 1) o.multi++;
         if (|{r0_enb_v[g], r1_enb_v[g], w0_enb_v[g]} && rd_ack_v[g]) o.multi++;
         if (o.ack_cyc < 0 && cmd_rdy_v[g]) o.rdy_busy++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         n_chk++;
         if ({cmd_rdy_v[g], rd_ack_v[g], err_v[g]} !== 3'b100) begin
            n_fail++; $display("FAIL reset_ctrl[%0d]: rdy/ack/err=%b want 100", g, {cmd_rdy_v[g], rd_ack_v[g], err_v[g]});
         end
         n_chk++;
         if ({r0_enb_v[g], r1_enb_v[g], w0_enb_v[g], r0_adr_v[g], r1_adr_v[g], w0_adr_v[g]} !== '0) begin
            n_fail++; $display("FAIL reset_enb_adr[%0d]: enb/adr not zero", g);
         end
         n_chk++;
         if ({rd_dat_v[g], w0_dat_v[g]} !== 64'h0) begin
            n_fail++; $display("FAIL reset_dat[%0d]: rd_dat=%h w0_dat=%h want 0", g, rd_dat_v[g], w0_dat_v[g]);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_full_wr_rd();
      obs_t o;
      do_cmd(0, 1'b1, 32'h0001_0014, 4'hF, 32'hA5A5_1234, o);
      n_chk++; if (o.w0_enb !== 2'b10 || o.w0_cyc != 1) begin
         n_fail++; $display("FAIL wr_w0_enb: enb=%b cyc=%0d want 10 at 1", o.w0_enb, o.w0_cyc); end
      n_chk++; if (o.w0_adr !== 5'd5 || o.w0_dat !== 32'hA5A5_1234) begin
         n_fail++; $display("FAIL wr_w0_adr_dat: adr=%0d dat=%h want 5 a5a51234", o.w0_adr, o.w0_dat); end
      n_chk++; if (o.ack_cyc != 3 || o.ack_cnt != 1 || o.ack_dat !== 32'h0) begin
         n_fail++; $display("FAIL wr_ack: cyc=%0d cnt=%0d dat=%h want 3 1 0", o.ack_cyc, o.ack_cnt, o.ack_dat); end
      n_chk++; if (o.r0_cyc >= 0 || o.r1_cyc >= 0 || o.multi != 0 || o.rdy_busy != 0) begin
         n_fail++; $display("FAIL wr_hygiene: r0=%0d r1=%0d multi=%0d busy=%0d", o.r0_cyc, o.r1_cyc, o.multi, o.rdy_busy); end
      do_cmd(0, 1'b0, 32'h0001_0014, 4'h0, 32'h0, o);
      n_chk++; if (o.r0_enb !== 2'b10 || o.r0_adr !== 5'd5 || o.r0_cyc != 1) begin
         n_fail++; $display("FAIL rd_r0: enb=%b adr=%0d cyc=%0d want 10 5 1", o.r0_enb, o.r0_adr, o.r0_cyc); end
      n_chk++; if (o.ack_cyc != 3 || o.ack_dat !== 32'hA5A5_1234) begin
         n_fail++; $display("FAIL rd_ack: cyc=%0d dat=%h want 3 a5a51234", o.ack_cyc, o.ack_dat); end
      n_chk++; if (o.w0_cyc >= 0 || o.r1_cyc >= 0 || o.multi != 0) begin
         n_fail++; $display("FAIL rd_hygiene: w0=%0d r1=%0d multi=%0d", o.w0_cyc, o.r1_cyc, o.multi); end
   endtask

   task automatic test_port1_read();
      obs_t o;
      do_cmd(0, 1'b1, 32'h0000_8008, 4'hF, 32'h1357_9BDF, o);
      n_chk++; if (o.w0_enb !== 2'b01 || o.w0_adr !== 5'd2 || o.ack_cyc != 3) begin
         n_fail++; $display("FAIL p1_preload: enb=%b adr=%0d ack=%0d want 01 2 3", o.w0_enb, o.w0_adr, o.ack_cyc); end
      do_cmd(0, 1'b0, 32'h0000_8008, 4'hF, 32'h0, o);
      n_chk++; if (o.r1_enb !== 2'b01 || o.r1_adr !== 5'd2 || o.r0_cyc >= 0) begin
         n_fail++; $display("FAIL p1_enb: r1_enb=%b r1_adr=%0d r0_cyc=%0d want 01 2 -1", o.r1_enb, o.r1_adr, o.r0_cyc); end
      n_chk++; if (o.ack_cyc != 3 || o.ack_dat !== 32'h1C58_9BDF) begin
         n_fail++; $display("FAIL p1_data: cyc=%0d dat=%h want 3 1c589bdf", o.ack_cyc, o.ack_dat); end
   endtask

   task automatic test_out_of_range();
      obs_t o;
      n_chk++; if (err_v[0] !== 1'b0) begin
         n_fail++; $display("FAIL oor_err_pre: err=%b want 0", err_v[0]); end
      do_cmd(0, 1'b0, 32'h0005_0000, 4'hF, 32'h0, o);
      n_chk++; if (o.ack_cyc != 1 || o.ack_dat !== 32'h0 || o.ack_cnt != 1) begin
         n_fail++; $display("FAIL oor_ack: cyc=%0d dat=%h cnt=%0d want 1 0 1", o.ack_cyc, o.ack_dat, o.ack_cnt); end
      n_chk++; if (o.r0_cyc >= 0 || o.r1_cyc >= 0 || o.w0_cyc >= 0) begin
         n_fail++; $display("FAIL oor_enb: r0=%0d r1=%0d w0=%0d want none", o.r0_cyc, o.r1_cyc, o.w0_cyc); end
      n_chk++; if (err_v[0] !== 1'b1) begin
         n_fail++; $display("FAIL oor_err_set: err=%b want 1", err_v[0]); end
      do_cmd(0, 1'b0, 32'h0001_0014, 4'hF, 32'h0, o);
      n_chk++; if (err_v[0] !== 1'b1 || o.ack_dat !== 32'hA5A5_1234) begin
         n_fail++; $display("FAIL oor_err_hold: err=%b dat=%h want 1 a5a51234", err_v[0], o.ack_dat); end
   endtask

   task automatic test_sel0_write();
      obs_t o;
      do_cmd(0, 1'b1, 32'h0001_0014, 4'h0, 32'hFFFF_FFFF, o);
      n_chk++; if (o.ack_cyc != 1 || o.w0_cyc >= 0 || o.r0_cyc >= 0) begin
         n_fail++; $display("FAIL sel0_ack: cyc=%0d w0=%0d r0=%0d want 1 -1 -1", o.ack_cyc, o.w0_cyc, o.r0_cyc); end
      do_cmd(0, 1'b0, 32'h0001_0014, 4'hF, 32'h0, o);
      n_chk++; if (o.ack_dat !== 32'hA5A5_1234) begin
         n_fail++; $display("FAIL sel0_untouched: dat=%h want a5a51234", o.ack_dat); end
   endtask

   // alternate write/read pairs as fast as cmd_rdy allows: one every 4 cycles
   task automatic test_back_to_back();
      int issued = 0, acks = 0, busy = 0, last_ack = -1, clash = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rd_ack_v[0]) begin
            acks++; last_ack = c;
            if (cmd_rdy_v[0]) clash++;
            n_chk++;
            if (rd_dat_v[0] !== (((issued - 1) % 2 == 1) ? 32'hC0DE_0000 + 32'((issued - 1) / 2) : 32'h0)) begin
               n_fail++; $display("FAIL b2b_dat[%0d]: got %h", issued - 1, rd_dat_v[0]);
            end
         end
         cmd_val[0] = 1'b0;
         if (cmd_rdy_v[0] && issued < 8) begin
            cmd_we  = (issued % 2 == 0);
            cmd_adr = 32'h40 + 32'(4 * (issued / 2));
            cmd_sel = 4'hF;
            cmd_dat = 32'hC0DE_0000 + 32'(issued / 2);
            cmd_val[0] = 1'b1;
            issued++;
         end else if (!cmd_rdy_v[0]) busy++;
      end
      n_chk++; if (acks != 8 || last_ack != 31) begin
         n_fail++; $display("FAIL b2b_acks: acks=%0d last=%0d want 8 31", acks, last_ack); end
      n_chk++; if (busy != 24 || clash != 0) begin
         n_fail++; $display("FAIL b2b_rdy: busy=%0d clash=%0d want 24 0", busy, clash); end
   endtask

   task automatic test_rmw();
      obs_t o;
      do_cmd(1, 1'b1, 32'h0000_0030, 4'hF, 32'h1122_3344, o);
      n_chk++; if (o.ack_cyc != 3 || o.w0_dat !== 32'h1122_3344) begin
         n_fail++; $display("FAIL rmw_preload: ack=%0d dat=%h want 3 11223344", o.ack_cyc, o.w0_dat); end
      do_cmd(1, 1'b1, 32'h0000_8030, 4'b0101, 32'hAABB_CCDD, o);
      n_chk++; if (o.r0_enb !== 2'b01 || o.r0_adr !== 5'd12 || o.r0_cyc != 1 || o.r1_cyc >= 0) begin
         n_fail++; $display("FAIL rmw_rd: enb=%b adr=%0d cyc=%0d r1=%0d want 01 12 1 -1", o.r0_enb, o.r0_adr, o.r0_cyc, o.r1_cyc); end
      n_chk++; if (o.w0_cyc != 4 || o.w0_enb !== 2'b01 || o.w0_dat !== 32'h11BB_33DD) begin
         n_fail++; $display("FAIL rmw_wr: cyc=%0d enb=%b dat=%h want 4 01 11bb33dd", o.w0_cyc, o.w0_enb, o.w0_dat); end
      n_chk++; if (o.ack_cyc != 6 || o.ack_dat !== 32'h0 || o.multi != 0) begin
         n_fail++; $display("FAIL rmw_ack: cyc=%0d dat=%h multi=%0d want 6 0 0", o.ack_cyc, o.ack_dat, o.multi); end
      do_cmd(1, 1'b0, 32'h0000_0030, 4'hF, 32'h0, o);
      n_chk++; if (o.ack_cyc != 4 || o.ack_dat !== 32'h11BB_33DD) begin
         n_fail++; $display("FAIL rmw_readback: cyc=%0d dat=%h want 4 11bb33dd", o.ack_cyc, o.ack_dat); end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      int acks = 0, low = 0;
      do_cmd(2, 1'b1, 32'h0001_0040, 4'hF, 32'h5A5A_0F0F, o);
      @(negedge clk);
      cmd_we = 1'b0; cmd_adr = 32'h0001_0040; cmd_sel = 4'hF; cmd_val[2] = 1'b1;
      @(negedge clk);
      cmd_val[2] = 1'b0;
      n_chk++; if (r0_enb_v[2] !== 2'b10) begin
         n_fail++; $display("FAIL rst_mid_rd: r0_enb=%b want 10", r0_enb_v[2]); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++; if ({r0_enb_v[2], r1_enb_v[2], w0_enb_v[2], rd_ack_v[2]} !== '0 || cmd_rdy_v[2] !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_drop: enb/ack not zero or rdy=%b", cmd_rdy_v[2]); end
      n_chk++; if (err_v[0] !== 1'b0) begin
         n_fail++; $display("FAIL rst_err_clear: err=%b want 0", err_v[0]); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rd_ack_v[2]) acks++;
         if (!cmd_rdy_v[2]) low++;
      end
      n_chk++; if (acks != 0 || low != 0) begin
         n_fail++; $display("FAIL rst_no_ack: acks=%0d rdy_low=%0d want 0 0", acks, low); end
      do_cmd(2, 1'b0, 32'h0001_0040, 4'hF, 32'h0, o);
      n_chk++; if (o.ack_cyc != 5 || o.ack_dat !== 32'h5A5A_0F0F || o.r0_enb !== 2'b10) begin
         n_fail++; $display("FAIL rst_next_rd: cyc=%0d dat=%h enb=%b want 5 5a5a0f0f 10", o.ack_cyc, o.ack_dat, o.r0_enb); end
   endtask

   initial begin
      test_reset();
      test_full_wr_rd();
      test_port1_read();
      test_out_of_range();
      test_sel0_write();
      test_back_to_back();
      test_rmw();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
